// File: rtl/pipe_if_stage.sv
// Instruction fetch stage and IF/ID register: owns the PC, talks to imem via req/ready,
// holds one early word in a skid buffer and applies branch/jump redirects from ID.
module pipe_if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          DELAY_SLOT = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  pcsrc,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    output logic [31:0] pc,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] dinst,
    output logic [31:0] dpc4,
    output logic        dvalid
);

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] BUF   = 2'd1;
    localparam logic [1:0] DROP  = 2'd2;

    localparam bit SLOT_EXEC = (DELAY_SLOT != 0);

    logic [1:0]  state;
    logic [1:0]  state_nx;
    logic [31:0] pc_nx;
    logic [31:0] dinst_nx;
    logic [31:0] dpc4_nx;
    logic        dvalid_nx;
    logic [31:0] buf_inst;
    logic [31:0] buf_inst_nx;
    logic [31:0] buf_pc4;
    logic [31:0] buf_pc4_nx;
    logic        pend_vld;
    logic        pend_vld_nx;
    logic [31:0] pend_pc;
    logic [31:0] pend_pc_nx;

    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic [31:0] seq_pc;
    logic        redirect;
    logic        complete;

    assign pc_plus4 = pc + 32'd4;
    assign redirect = (pcsrc != 2'b00) && !stall;
    assign imem_req = !reset && (state != BUF);
    assign complete = imem_req && imem_ready;
    // A delay-slot redirect latched while the slot was in flight wins over pc+4.
    assign seq_pc   = pend_vld ? pend_pc : pc_plus4;

    always_comb begin
        case (pcsrc)
            2'b01:   target = bpc;
            2'b10:   target = rpc;
            2'b11:   target = jpc;
            default: target = pc_plus4;
        endcase
    end

    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
        dinst_nx    = dinst;
        dpc4_nx     = dpc4;
        dvalid_nx   = dvalid;
        buf_inst_nx = buf_inst;
        buf_pc4_nx  = buf_pc4;
        pend_vld_nx = pend_vld;
        pend_pc_nx  = pend_pc;

        case (state)
            FETCH: begin
                if (complete) begin
                    if (stall) begin
                        // ID is busy: park the word, keep fetching address moving.
                        buf_inst_nx = imem_rdata;
                        buf_pc4_nx  = pc_plus4;
                        pc_nx       = seq_pc;
                        pend_vld_nx = 1'b0;
                        state_nx    = BUF;
                    end else if (redirect && !SLOT_EXEC) begin
                        pc_nx       = target;
                        dvalid_nx   = 1'b0;
                        pend_vld_nx = 1'b0;
                    end else begin
                        dinst_nx    = imem_rdata;
                        dpc4_nx     = pc_plus4;
                        dvalid_nx   = 1'b1;
                        pc_nx       = redirect ? target : seq_pc;
                        pend_vld_nx = 1'b0;
                    end
                end else if (!stall) begin
                    dvalid_nx = 1'b0;
                    if (redirect) begin
                        pend_pc_nx = target;
                        if (SLOT_EXEC) begin
                            pend_vld_nx = 1'b1;
                        end else begin
                            state_nx = DROP;
                        end
                    end
                end
            end

            BUF: begin
                if (!stall) begin
                    state_nx = FETCH;
                    if (redirect) begin
                        pc_nx = target;
                    end
                    if (redirect && !SLOT_EXEC) begin
                        dvalid_nx = 1'b0;
                    end else begin
                        dinst_nx  = buf_inst;
                        dpc4_nx   = buf_pc4;
                        dvalid_nx = 1'b1;
                    end
                end
            end

            DROP: begin
                if (!stall) begin
                    dvalid_nx = 1'b0;
                end
                if (redirect) begin
                    pend_pc_nx = target;
                end
                // The outstanding response belongs to the squashed path.
                if (complete) begin
                    pc_nx    = redirect ? target : pend_pc;
                    state_nx = FETCH;
                end
            end

            default: begin
                state_nx = FETCH;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            dinst    <= 32'd0;
            dpc4     <= 32'd0;
            dvalid   <= 1'b0;
            buf_inst <= 32'd0;
            buf_pc4  <= 32'd0;
            pend_vld <= 1'b0;
            pend_pc  <= 32'd0;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            dinst    <= dinst_nx;
            dpc4     <= dpc4_nx;
            dvalid   <= dvalid_nx;
            buf_inst <= buf_inst_nx;
            buf_pc4  <= buf_pc4_nx;
            pend_vld <= pend_vld_nx;
            pend_pc  <= pend_pc_nx;
        end
    end

endmodule

// File: tb/tb_pipe_if_stage.sv
// Bench for pipe_if_stage: table-driven cycle vectors with an instruction scoreboard,
// plus hand sequences for squash-with-wait-states and PC wrap.
module tb_pipe_if_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic [1:0]  pcsrc = 2'b00;
    logic        ready = 1'b1;
    logic [31:0] bpc = 32'h0000_0040;
    logic [31:0] rpc = 32'h0000_0200;
    logic [31:0] jpc = 32'h0000_0100;

    logic [31:0] pc1, rdata1, dinst1, dpc4_1;
    logic        req1, dvalid1;
    logic [31:0] pc0, rdata0, dinst0, dpc4_0;
    logic        req0, dvalid0;
    logic [31:0] pcw, rdataw, dinstw, dpc4_w;
    logic        reqw, dvalidw;

    always #5 clock = ~clock;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    assign rdata1 = mem(pc1);
    assign rdata0 = mem(pc0);
    assign rdataw = mem(pcw);

    pipe_if_stage #(.RESET_PC(32'h0000_0000), .DELAY_SLOT(1)) u_ds1 (
        .clock(clock), .reset(reset), .stall(stall), .pcsrc(pcsrc),
        .bpc(bpc), .rpc(rpc), .jpc(jpc), .pc(pc1), .imem_req(req1),
        .imem_ready(ready), .imem_rdata(rdata1), .dinst(dinst1), .dpc4(dpc4_1),
        .dvalid(dvalid1)
    );

    pipe_if_stage #(.RESET_PC(32'h0000_0000), .DELAY_SLOT(0)) u_ds0 (
        .clock(clock), .reset(reset), .stall(stall), .pcsrc(pcsrc),
        .bpc(bpc), .rpc(rpc), .jpc(jpc), .pc(pc0), .imem_req(req0),
        .imem_ready(ready), .imem_rdata(rdata0), .dinst(dinst0), .dpc4(dpc4_0),
        .dvalid(dvalid0)
    );

    pipe_if_stage #(.RESET_PC(32'hFFFF_FFFC), .DELAY_SLOT(1)) u_wrap (
        .clock(clock), .reset(reset), .stall(stall), .pcsrc(pcsrc),
        .bpc(bpc), .rpc(rpc), .jpc(jpc), .pc(pcw), .imem_req(reqw),
        .imem_ready(ready), .imem_rdata(rdataw), .dinst(dinstw), .dpc4(dpc4_w),
        .dvalid(dvalidw)
    );

    typedef struct {
        logic        rst;
        logic        stl;
        logic [1:0]  src;
        logic        rdy;
        logic        req;
        logic [31:0] pc;
        logic        dv;
        logic [31:0] dpc4;
    } vec_t;

    vec_t        vq[$];
    logic [31:0] sb_q[$];
    int          checks = 0;
    int          failures = 0;

    task automatic add(input logic rst, input logic stl, input logic [1:0] src, input logic rdy,
                       input logic req, input logic [31:0] p, input logic dv, input logic [31:0] d4);
        vec_t v;
        v.rst = rst; v.stl = stl; v.src = src; v.rdy = rdy;
        v.req = req; v.pc = p; v.dv = dv; v.dpc4 = d4;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [31:0] exp_inst;
        //  rst   stl   src    rdy  | req   pc            dv    dpc4
        add(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000);
        add(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0004);
        add(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0008);
        add(1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 32'h0000_000C, 1'b1, 32'h0000_0008);
        add(1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 32'h0000_000C, 1'b1, 32'h0000_0008);
        add(1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 32'h0000_000C, 1'b1, 32'h0000_0008);
        add(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 32'h0000_000C, 1'b1, 32'h0000_000C);
        add(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_0010);
        add(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 32'h0000_0014, 1'b1, 32'h0000_0014);
        add(1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 32'h0000_0040, 1'b1, 32'h0000_0018);
        add(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 32'h0000_0044, 1'b1, 32'h0000_0044);
        add(1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 32'h0000_0048, 1'b1, 32'h0000_0044);
        add(1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 32'h0000_0048, 1'b1, 32'h0000_0044);
        add(1'b0, 1'b0, 2'b11, 1'b1, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0048);
        add(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 32'h0000_0104, 1'b1, 32'h0000_0104);
        add(1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 32'h0000_0104, 1'b0, 32'h0000_0104);
        add(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 32'h0000_0200, 1'b1, 32'h0000_0108);
        add(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 32'h0000_0204, 1'b1, 32'h0000_0204);
        add(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 32'h0000_0204, 1'b1, 32'h0000_0204);
        add(1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 32'h0000_0204, 1'b0, 32'h0000_0204);
        add(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 32'h0000_0208, 1'b1, 32'h0000_0208);
        add(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000);
        add(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000);
        add(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0004);
        add(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0008);
        add(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 32'h0000_000C, 1'b1, 32'h0000_000C);

        for (int i = 0; i < vq.size(); i++) begin
            reset = vq[i].rst;
            stall = vq[i].stl;
            pcsrc = vq[i].src;
            ready = vq[i].rdy;
            if (!vq[i].rst && !vq[i].stl && vq[i].dv)
                sb_q.push_back(mem(vq[i].dpc4 - 32'd4));
            step();
            chk($sformatf("v%0d imem_req", i), 32'(req1), 32'(vq[i].req));
            chk($sformatf("v%0d pc", i), pc1, vq[i].pc);
            chk($sformatf("v%0d dvalid", i), 32'(dvalid1), 32'(vq[i].dv));
            chk($sformatf("v%0d dpc4", i), dpc4_1, vq[i].dpc4);
            if (!reset && !stall && dvalid1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL v%0d scoreboard: got delivery %h expected none", i, dinst1);
                end else begin
                    exp_inst = sb_q.pop_front();
                    chk($sformatf("v%0d dinst", i), dinst1, exp_inst);
                end
            end
        end
        chk("scoreboard leftover", 32'(sb_q.size()), 32'd0);

        // Hand sequence: DELAY_SLOT=0 squash paths and the wrapping reset PC.
        reset = 1'b1; stall = 1'b0; pcsrc = 2'b00; ready = 1'b1;
        step();
        chk("wrap reset pc", pcw, 32'hFFFF_FFFC);
        chk("wrap reset req", 32'(reqw), 32'd0);
        reset = 1'b0;
        step();
        chk("wrap dpc4", dpc4_w, 32'h0000_0000);
        chk("wrap dinst", dinstw, mem(32'hFFFF_FFFC));
        chk("wrap dvalid", 32'(dvalidw), 32'd1);
        chk("wrap pc", pcw, 32'h0000_0000);
        chk("ds0 pc 4", pc0, 32'h0000_0004);
        step();
        chk("wrap next dpc4", dpc4_w, 32'h0000_0004);
        chk("wrap next dinst", dinstw, mem(32'h0000_0000));
        step();
        step();
        chk("ds0 pc 10", pc0, 32'h0000_0010);
        chk("ds0 dpc4 10", dpc4_0, 32'h0000_0010);
        ready = 1'b0; pcsrc = 2'b11;
        step();
        chk("ds0 drop pc held", pc0, 32'h0000_0010);
        chk("ds0 drop dvalid", 32'(dvalid0), 32'd0);
        chk("ds0 drop req", 32'(req0), 32'd1);
        pcsrc = 2'b00;
        step();
        chk("ds0 drop wait pc", pc0, 32'h0000_0010);
        chk("ds0 drop wait dvalid", 32'(dvalid0), 32'd0);
        ready = 1'b1;
        step();
        chk("ds0 drop done pc", pc0, 32'h0000_0100);
        chk("ds0 drop done dvalid", 32'(dvalid0), 32'd0);
        step();
        chk("ds0 target dpc4", dpc4_0, 32'h0000_0104);
        chk("ds0 target dinst", dinst0, mem(32'h0000_0100));
        chk("ds0 target dvalid", 32'(dvalid0), 32'd1);
        pcsrc = 2'b01;
        step();
        chk("ds0 squash pc", pc0, 32'h0000_0040);
        chk("ds0 squash dvalid", 32'(dvalid0), 32'd0);
        pcsrc = 2'b00;
        step();
        chk("ds0 branch dpc4", dpc4_0, 32'h0000_0044);
        chk("ds0 branch dinst", dinst0, mem(32'h0000_0040));
        stall = 1'b1;
        step();
        chk("ds0 buf pc", pc0, 32'h0000_0048);
        chk("ds0 buf req", 32'(req0), 32'd0);
        chk("ds0 buf dpc4 hold", dpc4_0, 32'h0000_0044);
        stall = 1'b0; pcsrc = 2'b10;
        step();
        chk("ds0 buf flush dvalid", 32'(dvalid0), 32'd0);
        chk("ds0 buf flush pc", pc0, 32'h0000_0200);
        chk("ds0 buf flush req", 32'(req0), 32'd1);
        pcsrc = 2'b00;
        step();
        chk("ds0 rjump dpc4", dpc4_0, 32'h0000_0204);
        chk("ds0 rjump dinst", dinst0, mem(32'h0000_0200));
        chk("ds0 rjump dvalid", 32'(dvalid0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
